// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer for an 8259-compatible PIC (8086 two-pulse INTA only).
// Owns INT to the CPU, freezes the resolver, sets/clears ISR bits and steers cascade/data drive.
module inta_sequencer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INTA_N,
  input  logic       INT_REQ,
  input  logic [2:0] HIGHEST_IR,
  input  logic       SNGL,
  input  logic       SP_EN,
  input  logic [7:0] ICW3,
  input  logic [4:0] ICW2_T,
  input  logic       AEOI,
  input  logic [2:0] CAS_IN,
  output logic       INT,
  output logic       FREEZE,
  output logic [7:0] ISR_SET,
  output logic [7:0] AEOI_CLR,
  output logic [2:0] CAS_OUT,
  output logic       CAS_OE,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE
);

  typedef enum logic [1:0] {StIdle, StAck1, StGap, StAck2} state_e;

  state_e     state_q, state_d;
  logic       inta_q;
  logic       fall, rise;
  logic [2:0] ir_q, ir_d;
  logic       spur_q, spur_d;
  logic       casc_q, casc_d;
  logic       drive;

  logic       int_d, freeze_d, cas_oe_d, data_oe_d;
  logic [7:0] isr_set_d, aeoi_clr_d, data_out_d;
  logic [2:0] cas_out_d;

  assign fall  = inta_q & ~INTA_N;
  assign rise  = ~inta_q & INTA_N;
  // Single mode, a master whose IR has no slave, or a slave addressed on CAS puts out the vector.
  assign drive = SNGL | (SP_EN & ~casc_q) | (~SP_EN & (CAS_IN == ICW3[2:0]));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (fall) state_d = StAck1;
      StAck1: if (rise) state_d = StGap;
      StGap:  if (fall) state_d = StAck2;
      StAck2: if (rise) state_d = StIdle;
    endcase
  end

  always_comb begin
    ir_d       = ir_q;
    spur_d     = spur_q;
    casc_d     = casc_q;
    int_d      = 1'b0;
    freeze_d   = FREEZE;
    isr_set_d  = 8'h00;
    aeoi_clr_d = 8'h00;
    cas_out_d  = CAS_OUT;
    cas_oe_d   = CAS_OE;
    data_out_d = DATA_OUT;
    data_oe_d  = DATA_OE;
    unique case (state_q)
      StIdle: begin
        int_d = INT_REQ;
        if (fall) begin
          // No request at the first pulse is spurious and answers as IR7.
          spur_d    = ~INT_REQ;
          ir_d      = INT_REQ ? HIGHEST_IR : 3'd7;
          casc_d    = ~SNGL & SP_EN & ICW3[ir_d] & INT_REQ;
          int_d     = 1'b0;
          freeze_d  = 1'b1;
          isr_set_d = INT_REQ ? (8'd1 << ir_d) : 8'h00;
          if (casc_d) begin
            cas_out_d = ir_d;
            cas_oe_d  = 1'b1;
          end
        end
      end
      StAck1: ;
      StGap: begin
        if (fall && drive) begin
          data_oe_d  = 1'b1;
          data_out_d = {ICW2_T, ir_q};
        end
      end
      StAck2: begin
        if (rise) begin
          data_oe_d  = 1'b0;
          cas_oe_d   = 1'b0;
          cas_out_d  = 3'd0;
          freeze_d   = 1'b0;
          aeoi_clr_d = (AEOI && !spur_q) ? (8'd1 << ir_q) : 8'h00;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      inta_q   <= 1'b1;
      ir_q     <= 3'd0;
      spur_q   <= 1'b0;
      casc_q   <= 1'b0;
      INT      <= 1'b0;
      FREEZE   <= 1'b0;
      ISR_SET  <= 8'h00;
      AEOI_CLR <= 8'h00;
      CAS_OUT  <= 3'd0;
      CAS_OE   <= 1'b0;
      DATA_OUT <= 8'h00;
      DATA_OE  <= 1'b0;
    end else begin
      inta_q   <= INTA_N;
      ir_q     <= ir_d;
      spur_q   <= spur_d;
      casc_q   <= casc_d;
      INT      <= int_d;
      FREEZE   <= freeze_d;
      ISR_SET  <= isr_set_d;
      AEOI_CLR <= aeoi_clr_d;
      CAS_OUT  <= cas_out_d;
      CAS_OE   <= cas_oe_d;
      DATA_OUT <= data_out_d;
      DATA_OE  <= data_oe_d;
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: each acknowledge is a transaction whose expected outputs per phase
// are derived up front from the configuration and the request seen at the first INTA fall.
module tb_inta_sequencer;

  logic       CLK = 1'b0;
  logic       RST, INTA_N, INT_REQ, SNGL, SP_EN, AEOI;
  logic [2:0] HIGHEST_IR, CAS_IN;
  logic [7:0] ICW3;
  logic [4:0] ICW2_T;
  logic       INT, FREEZE, CAS_OE, DATA_OE;
  logic [7:0] ISR_SET, AEOI_CLR, DATA_OUT;
  logic [2:0] CAS_OUT;

  inta_sequencer dut (
    .CLK(CLK), .RST(RST), .INTA_N(INTA_N), .INT_REQ(INT_REQ), .HIGHEST_IR(HIGHEST_IR),
    .SNGL(SNGL), .SP_EN(SP_EN), .ICW3(ICW3), .ICW2_T(ICW2_T), .AEOI(AEOI), .CAS_IN(CAS_IN),
    .INT(INT), .FREEZE(FREEZE), .ISR_SET(ISR_SET), .AEOI_CLR(AEOI_CLR), .CAS_OUT(CAS_OUT),
    .CAS_OE(CAS_OE), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] hold_dout;
  logic [7:0] cap_isr, cap_dout, cap_aeoi;
  logic [2:0] cap_casout;
  logic       cap_doe, cap_casoe, cap_int_pre;

  task automatic check(input string tag, input logic [31:0] seen, input logic [31:0] exp);
    n_tests++;
    if (seen !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, seen, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_outs(input string ph, input logic e_int, input logic e_frz,
                             input logic [7:0] e_isr, input logic [7:0] e_aeoi,
                             input logic [2:0] e_co, input logic e_coe, input logic e_doe);
    check({ph, ".INT"}, INT, e_int);
    check({ph, ".FREEZE"}, FREEZE, e_frz);
    check({ph, ".ISR_SET"}, ISR_SET, e_isr);
    check({ph, ".AEOI_CLR"}, AEOI_CLR, e_aeoi);
    check({ph, ".CAS_OUT"}, CAS_OUT, e_co);
    check({ph, ".CAS_OE"}, CAS_OE, e_coe);
    check({ph, ".DATA_OE"}, DATA_OE, e_doe);
    check({ph, ".DATA_OUT"}, DATA_OUT, hold_dout);
  endtask

  task automatic jitter();
    INT_REQ    = 1'($urandom);
    HIGHEST_IR = 3'($urandom);
  endtask

  // One full INTA pulse pair; widths count CLK samples per phase (all >= 1).
  task automatic ack(input int idle, input int l1, input int h, input int l2,
                     input logic req, input logic [2:0] hir, input logic rst_gap);
    logic       spur, casc, drive;
    logic [2:0] ir, co;
    logic [7:0] vec, isr_e, aeoi_e;
    spur   = !req;
    ir     = spur ? 3'd7 : hir;
    casc   = !SNGL && SP_EN && ICW3[ir] && !spur;
    drive  = SNGL || (SP_EN && !casc) || (!SP_EN && (CAS_IN == ICW3[2:0]));
    vec    = {ICW2_T, ir};
    isr_e  = spur ? 8'h00 : (8'd1 << ir);
    aeoi_e = (AEOI && !spur) ? (8'd1 << ir) : 8'h00;
    co     = casc ? ir : 3'd0;

    for (int i = 0; i < idle; i++) begin
      INTA_N = 1'b1;
      jitter();
      if (i == idle - 1) INT_REQ = req;
      tick();
      expect_outs("idle", INT_REQ, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      cap_int_pre = INT;
    end
    INTA_N = 1'b0; INT_REQ = req; HIGHEST_IR = hir;
    tick();
    expect_outs("fall1", 1'b0, 1'b1, isr_e, 8'h00, co, casc, 1'b0);
    cap_isr = ISR_SET; cap_casout = CAS_OUT; cap_casoe = CAS_OE;
    for (int i = 1; i < l1; i++) begin
      jitter();
      tick();
      expect_outs("low1", 1'b0, 1'b1, 8'h00, 8'h00, co, casc, 1'b0);
    end
    for (int i = 0; i < h; i++) begin
      INTA_N = 1'b1;
      jitter();
      tick();
      expect_outs("gap", 1'b0, 1'b1, 8'h00, 8'h00, co, casc, 1'b0);
    end
    if (rst_gap) begin
      RST = 1'b1;
      tick();
      hold_dout = 8'h00;
      expect_outs("rst_gap", 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      RST = 1'b0;
      return;
    end
    INTA_N = 1'b0;
    jitter();
    tick();
    if (drive) hold_dout = vec;
    expect_outs("fall2", 1'b0, 1'b1, 8'h00, 8'h00, co, casc, drive);
    cap_dout = DATA_OUT; cap_doe = DATA_OE;
    for (int i = 1; i < l2; i++) begin
      jitter();
      tick();
      expect_outs("low2", 1'b0, 1'b1, 8'h00, 8'h00, co, casc, drive);
    end
    INTA_N = 1'b1;
    jitter();
    tick();
    expect_outs("rise2", 1'b0, 1'b0, 8'h00, aeoi_e, 3'd0, 1'b0, 1'b0);
    cap_aeoi = AEOI_CLR;
  endtask

  initial begin
    RST = 1'b1; INTA_N = 1'b1; INT_REQ = 1'b0; HIGHEST_IR = 3'd0;
    SNGL = 1'b1; SP_EN = 1'b1; ICW3 = 8'h00; ICW2_T = 5'd0; AEOI = 1'b0; CAS_IN = 3'd0;
    hold_dout = 8'h00;
    tick();
    tick();
    expect_outs("reset", 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    RST = 1'b0;

    // Single mode, normal acknowledge
    SNGL = 1'b1; ICW2_T = 5'b01000;
    ack(2, 2, 1, 2, 1'b1, 3'd3, 1'b0);
    check("single.int_pre", cap_int_pre, 1'b1);
    check("single.isr", cap_isr, 8'h08);
    check("single.dout", cap_dout, 8'h43);
    check("single.doe", cap_doe, 1'b1);
    check("single.casoe", cap_casoe, 1'b0);

    // Master with a slave on IR2
    SNGL = 1'b0; SP_EN = 1'b1; ICW3 = 8'h04;
    ack(1, 1, 2, 1, 1'b1, 3'd2, 1'b0);
    check("master.casout", cap_casout, 3'd2);
    check("master.casoe", cap_casoe, 1'b1);
    check("master.doe", cap_doe, 1'b0);

    // Slave ID 5: match then mismatch
    SP_EN = 1'b0; ICW3 = 8'h05; ICW2_T = 5'b10010; CAS_IN = 3'd5;
    ack(1, 1, 1, 1, 1'b1, 3'd1, 1'b0);
    check("slave.dout", cap_dout, 8'h91);
    check("slave.doe", cap_doe, 1'b1);
    CAS_IN = 3'd4;
    ack(0, 1, 1, 1, 1'b1, 3'd1, 1'b0);
    check("slave_miss.doe", cap_doe, 1'b0);

    // Spurious acknowledge with auto-EOI enabled
    SNGL = 1'b1; SP_EN = 1'b1; ICW2_T = 5'b01000; AEOI = 1'b1;
    ack(1, 1, 1, 1, 1'b0, 3'd5, 1'b0);
    check("spur.isr", cap_isr, 8'h00);
    check("spur.dout", cap_dout, 8'h47);
    check("spur.aeoi", cap_aeoi, 8'h00);

    // Auto-EOI on IR6, back to back
    ack(0, 2, 1, 1, 1'b1, 3'd6, 1'b0);
    check("aeoi.clr", cap_aeoi, 8'h40);

    // Reset in GAP with cascade driven, then stray edges, then a clean acknowledge
    SNGL = 1'b0; SP_EN = 1'b1; ICW3 = 8'hff; AEOI = 1'b0;
    ack(1, 1, 1, 1, 1'b1, 3'd4, 1'b1);
    RST = 1'b1; INTA_N = 1'b0;
    tick();
    expect_outs("rst_low", 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    RST = 1'b0; INTA_N = 1'b1; INT_REQ = 1'b0;
    tick();
    expect_outs("post_rst", 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    ack(1, 1, 1, 1, 1'b1, 3'd4, 1'b0);
    check("post_rst.casout", cap_casout, 3'd4);

    // Randomized acknowledges across all configurations
    for (int n = 0; n < 200; n++) begin
      SNGL   = 1'($urandom);
      SP_EN  = 1'($urandom);
      ICW3   = 8'($urandom);
      ICW2_T = 5'($urandom);
      AEOI   = 1'($urandom);
      CAS_IN = ($urandom_range(0, 1) == 0) ? ICW3[2:0] : 3'($urandom);
      ack($urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(1, 3),
          $urandom_range(1, 3), ($urandom_range(0, 7) != 0), 3'($urandom),
          ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
